// File: rtl/shift_pipe_stage.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both sides.
// Bubbles collapse forward so a downstream stall fills empty stages before back-pressuring.
module shift_pipe_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [WIDTH*DEPTH-1:0]       tap_data,
  output logic [DEPTH-1:0]             tap_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] move;
  logic             carry;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance if out_ready is high or any stage at or beyond it is empty;
  // computed as a running OR from the output end so the chain has no self-reference.
  always_comb begin
    carry = out_ready;
    move  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      carry               = carry | ~stage_valid[DEPTH-1-i];
      move[DEPTH-1-i]     = carry;
    end
  end

  assign in_ready  = move[0] & ~flush;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign tap_valid = stage_valid;

  always_comb begin
    tap_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tap_data[i*WIDTH +: WIDTH] = stage_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
      end
    end else if (flush) begin
      stage_valid <= '0;
      count       <= '0;
    end else begin
      // Data registers load only behind a valid item, so bubbles leave stale data in place.
      if (move[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) stage_data[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (move[i]) begin
          stage_valid[i] <= stage_valid[i-1];
          if (stage_valid[i-1]) stage_data[i] <= stage_data[i-1];
        end
      end
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Bench for shift_pipe_stage: directed scenarios then random traffic, checked each cycle
// against an item/position model of the pipeline.
module tb_shift_pipe_stage;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH+1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [WIDTH*DEPTH-1:0] tap_data;
  logic [DEPTH-1:0]       tap_valid;
  logic [CW-1:0]          count;

  shift_pipe_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tap_data(tap_data), .tap_valid(tap_valid), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } item_t;

  item_t            q[$];          // items in flight, oldest (furthest along) first
  logic [WIDTH-1:0] sd [DEPTH];    // last data that arrived at each stage
  int               errors = 0;
  int               checks = 0;
  bit               accepted;
  logic             r_iv, r_or, r_fl;
  logic [WIDTH-1:0] r_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < DEPTH; k++) sd[k] = '0;
  endtask

  // An item at position p advances when the consumer takes or when fewer items than
  // slots occupy positions p..DEPTH-1; a new item enters when any slot is free or the head leaves.
  task automatic model_step(input logic iv, input logic [WIDTH-1:0] d,
                            input logic ordy, input logic fl);
    item_t nq[$];
    int    n;
    n = q.size();
    accepted = 0;
    if (fl) begin
      q.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      item_t it;
      it = q[i];
      if (ordy || (i + 1 < DEPTH - it.pos)) begin
        it.pos++;
        if (it.pos < DEPTH) begin
          sd[it.pos] = it.d;
          nq.push_back(it);
        end
      end else begin
        nq.push_back(it);
      end
    end
    if (iv && (ordy || n < DEPTH)) begin
      item_t ni;
      ni.d = d;
      ni.pos = 0;
      sd[0] = d;
      nq.push_back(ni);
      accepted = 1;
    end
    q = nq;
  endtask

  task automatic compare_all();
    logic [DEPTH-1:0]       tv;
    logic [WIDTH*DEPTH-1:0] td;
    logic                   rdy;
    tv = '0;
    foreach (q[i]) tv[q[i].pos] = 1'b1;
    for (int k = 0; k < DEPTH; k++) td[k*WIDTH +: WIDTH] = sd[k];
    rdy = !flush && (out_ready || q.size() < DEPTH);
    chk("in_ready",  32'(in_ready),  32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(tv[DEPTH-1]));
    chk("out_data",  32'(out_data),  32'(sd[DEPTH-1]));
    chk("count",     32'(count),     32'(q.size()));
    chk("tap_valid", 32'(tap_valid), 32'(tv));
    chk("tap_data",  32'(tap_data),  32'(td));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    compare_all();
    model_step(iv, d, ordy, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic ordy);
    bit done;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      cycle(1'b1, d, ordy, 1'b0);
      done = accepted;
    end
    chk("push_accept", 32'(done), 32'd1);
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int t = 0; t < n; t++) cycle(1'b0, '0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_tap_valid", 32'(tap_valid), 32'd0);

    // streaming 0..3 at full rate
    for (int i = 0; i < 4; i++) push(WIDTH'(i), 1'b1);
    idle(1'b1, 4);

    // stalled consumer: 5,6,7 fill, 8 waits upstream
    push(4'd5, 1'b0);
    push(4'd6, 1'b0);
    push(4'd7, 1'b0);
    chk("full_count", 32'(count), 32'd3);
    cycle(1'b1, 4'd8, 1'b0, 1'b0);
    cycle(1'b1, 4'd8, 1'b0, 1'b0);
    push(4'd8, 1'b1);
    idle(1'b1, 4);

    // bubble collapse behind a stalled head
    push(4'd9, 1'b0);
    idle(1'b0, 1);
    push(4'd10, 1'b0);
    idle(1'b0, 1);
    #1;
    chk("collapse_tap_valid", 32'(tap_valid), 32'b110);
    chk("collapse_out_data",  32'(out_data),  32'd9);
    idle(1'b0, 2);
    idle(1'b1, 4);

    // flush of a full pipe with a simultaneous offer
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    push(4'd3, 1'b0);
    cycle(1'b1, 4'd11, 1'b0, 1'b1);
    #1;
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_tap_valid", 32'(tap_valid), 32'd0);
    idle(1'b1, 2);

    // asynchronous reset between edges with two items held
    push(4'd12, 1'b0);
    push(4'd13, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count",     32'(count),     32'd0);
    chk("arst_tap_data",  32'(tap_data),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(WIDTH'(i + 4), 1'b1);
    idle(1'b1, 4);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r_iv = ($urandom_range(0, 3) != 0);
      r_d  = WIDTH'($urandom);
      r_or = ($urandom_range(0, 2) != 0);
      r_fl = ($urandom_range(0, 31) == 0);
      cycle(r_iv, r_d, r_or, r_fl);
    end
    idle(1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
